dnn_dot: RTL and testbench
==========================

DNN_DOT -- requirements
Module: dnn_dot

Interface
REQ-001 SHALL have no parameters; all widths fixed as listed.
REQ-002 SHALL have one clock and synchronous active-high reset: `clk  in  1  system clock; all logic on rising edge`.
REQ-003 `rst  in  1  synchronous active-high reset`.
REQ-004 `slave_waitrequest  out  1  CPU-side stall`.
REQ-005 `slave_address  in  4  word offset`.
REQ-006 `slave_read  in  1`; `slave_write  in  1`.
REQ-007 `slave_writedata  in  32`; `slave_readdata  out  32`.
REQ-008 `master_waitrequest  in  1  memory-side stall`.
REQ-009 `master_address  out  32  byte address`.
REQ-010 `master_read  out  1`; `master_readdata  in  32`; `master_readdatavalid  in  1`.
REQ-011 `master_write  out  1`; `master_writedata  out  32`.

Function
REQ-012 SHALL compute the Q16.16 signed dot product of two word vectors held in memory.
REQ-013 Slave register map (word offset):
- 0: write = start; read = result.
- 2: weight base address.
- 3: input base address.
- 5: length N in words.
- 7: control, bit0 = ReLU (see Configuration).
- Any other offset: reads 0; writes are ignored.
REQ-014 State machine: IDLE -> RD_W -> RD_I -> MAC -> (RD_W while count < N, else DONE) -> IDLE. DONE SHALL last exactly one cycle.
REQ-015 Memory reads:
- At most one read SHALL be outstanding.
- master_read SHALL be held with a stable address until a cycle with master_waitrequest=0.
- Data SHALL be captured only on master_readdatavalid=1.
REQ-016 Element k SHALL be read at base+4k; addresses SHALL be computed modulo 2^32.
REQ-017 MAC arithmetic:
- Product = 64-bit signed w*x.
- Accumulate product[47:16] into a 32-bit signed accumulator with two's-complement wrap.
- No saturation.
REQ-018 N=0: SHALL go IDLE -> DONE with result 0 and issue no master transaction.
REQ-019 A write to offset 0 in IDLE SHALL clear the accumulator and latch the config registers. The latched config SHALL be used for the whole run.
REQ-020 Writes to offset 0 while busy:
- slave_waitrequest SHALL be 1 until IDLE.
- The write then completes as a new start.
REQ-021 Reads of offset 0 while busy SHALL stall with slave_waitrequest=1. In the cycle after DONE they SHALL return the final result.
REQ-022 Reads and writes of offsets other than 0 SHALL never stall.
- Writes take effect next cycle.
- Writes while busy SHALL NOT affect the current run.
REQ-023 master_write SHALL be constant 0 and master_writedata constant 0.
REQ-024 Throughput: one MAC per element pair plus memory latency. There SHALL be no idle cycle between MAC and the next RD_W request.

Reset
REQ-025 On rst=1 at a clock edge, the block SHALL:
- enter IDLE;
- set accumulator, result, config registers and count to 0;
- drive master_read=0 and slave_waitrequest=0 the following cycle.
REQ-026 Reset mid-run SHALL abandon the run. A master_readdatavalid arriving after reset SHALL be ignored.

Configuration
REQ-027 Macro DNN_DOT_RELU_EN.
- Defined: offset 7 bit0 is readable and writable. When the latched bit is 1, a negative final result SHALL be replaced by 0 at DONE.
- Undefined: offset 7 SHALL read 0, writes are ignored, and no clamp logic is present.

Verification
REQ-028 Stimulus: N=3, w={1.0,2.0,-0.5}, x={2.0,0.25,4.0} (0x00010000...); start; read offset 0. Required: 0x00008000 (0.5 = 2+0.5-2).
REQ-029 Stimulus: N=0, start. Required: zero master_read pulses; offset-0 read returns 0 after at most 3 cycles.
REQ-030 Stimulus: random master_waitrequest (50%) and readdatavalid latency 1-8 cycles, N=16. Required:
- result matches the reference model;
- never more than one read outstanding;
- address stable while stalled.
REQ-031 Stimulus: DNN_DOT_RELU_EN defined, control=1, N=1, w=-1.0, x=1.0. Required: result 0. With control=0, result 0xFFFF0000.
REQ-032 Stimulus: assert rst during RD_I of N=4, then late readdatavalid, then new run N=1, w=x=1.0. Required: result 0x00010000.

Source files
------------

// File: rtl/dnn_dot.sv
// Q16.16 signed dot-product engine: slave register port to configure and start a run,
// master read port to fetch weight/input vectors. Optional macro: DNN_DOT_RELU_EN.
module dnn_dot (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic [31:0] slave_readdata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD_W = 3'd1;
  localparam logic [2:0] RD_I = 3'd2;
  localparam logic [2:0] MAC  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]  state;
  logic        issued;
  logic [31:0] cfg_wbase, cfg_ibase, cfg_len;
  logic [31:0] run_wbase, run_ibase, run_len;
  logic [31:0] count, count_next, acc, result, w_reg, x_reg;
  logic signed [63:0] w_ext, x_ext, product;
  logic [31:0] mac_term;
  logic        start, reg_write;
`ifdef DNN_DOT_RELU_EN
  logic        cfg_relu, run_relu;
`endif

  // Only result/start accesses wait for the engine; register accesses never stall.
  assign slave_waitrequest = (state != IDLE) && (slave_address == 4'd0) &&
                             (slave_read || slave_write);
  assign start     = (state == IDLE) && slave_write && (slave_address == 4'd0);
  assign reg_write = slave_write && (slave_address != 4'd0);

  assign master_read      = ((state == RD_W) || (state == RD_I)) && !issued;
  assign master_address   = ((state == RD_W) ? run_wbase : run_ibase) + {count[29:0], 2'b00};
  assign master_write     = 1'b0;
  assign master_writedata = 32'd0;

  assign w_ext      = {{32{w_reg[31]}}, w_reg};
  assign x_ext      = {{32{x_reg[31]}}, x_reg};
  assign product    = w_ext * x_ext;
  assign mac_term   = 32'(product >>> 16);
  assign count_next = count + 32'd1;

  always_comb begin
    slave_readdata = 32'd0;
    case (slave_address)
      4'd0: slave_readdata = result;
      4'd2: slave_readdata = cfg_wbase;
      4'd3: slave_readdata = cfg_ibase;
      4'd5: slave_readdata = cfg_len;
`ifdef DNN_DOT_RELU_EN
      4'd7: slave_readdata = {31'd0, cfg_relu};
`endif
      default: slave_readdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_wbase <= 32'd0;
      cfg_ibase <= 32'd0;
      cfg_len   <= 32'd0;
`ifdef DNN_DOT_RELU_EN
      cfg_relu  <= 1'b0;
`endif
    end else if (reg_write) begin
      case (slave_address)
        4'd2: cfg_wbase <= slave_writedata;
        4'd3: cfg_ibase <= slave_writedata;
        4'd5: cfg_len   <= slave_writedata;
`ifdef DNN_DOT_RELU_EN
        4'd7: cfg_relu  <= slave_writedata[0];
`endif
        default: ;
      endcase
    end
  end

  // The run works only from the snapshot taken at start, so register writes mid-run are harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issued    <= 1'b0;
      run_wbase <= 32'd0;
      run_ibase <= 32'd0;
      run_len   <= 32'd0;
      count     <= 32'd0;
      acc       <= 32'd0;
      result    <= 32'd0;
      w_reg     <= 32'd0;
      x_reg     <= 32'd0;
`ifdef DNN_DOT_RELU_EN
      run_relu  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            run_wbase <= cfg_wbase;
            run_ibase <= cfg_ibase;
            run_len   <= cfg_len;
`ifdef DNN_DOT_RELU_EN
            run_relu  <= cfg_relu;
`endif
            count     <= 32'd0;
            acc       <= 32'd0;
            state     <= (cfg_len == 32'd0) ? DONE : RD_W;
          end
        end
        RD_W, RD_I: begin
          if (master_read && !master_waitrequest) begin
            issued <= 1'b1;
          end else if (issued && master_readdatavalid) begin
            issued <= 1'b0;
            if (state == RD_W) begin
              w_reg <= master_readdata;
              state <= RD_I;
            end else begin
              x_reg <= master_readdata;
              state <= MAC;
            end
          end
        end
        MAC: begin
          acc   <= acc + mac_term;
          count <= count_next;
          state <= (count_next < run_len) ? RD_W : DONE;
        end
        DONE: begin
`ifdef DNN_DOT_RELU_EN
          result <= (run_relu && acc[31]) ? 32'd0 : acc;
`else
          result <= acc;
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_dot.sv
// Directed bench for dnn_dot with a behavioural memory slave (stall and latency control).
// Honours DNN_DOT_RELU_EN when the design is built with it.
module tb_dnn_dot;

  localparam int BUDGET = 2000;
`ifdef DNN_DOT_RELU_EN
  localparam logic [31:0] RELU_READ = 32'd1;
  localparam logic [31:0] RELU_NEG  = 32'd0;
`else
  localparam logic [31:0] RELU_READ = 32'd0;
  localparam logic [31:0] RELU_NEG  = 32'hFFFF0000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = 4'd0;
  logic        slave_read = 1'b0;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = 32'd0;
  logic [31:0] slave_readdata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:1023];
  bit          rand_wait = 1'b0;
  int          fixed_delay = 1;
  bit          pending = 1'b0;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          accepts = 0;
  int          overlap_viol = 0;
  int          stall_viol = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr;
  logic [31:0] addr_log [$];

  dnn_dot dut (
    .clk                  (clk),
    .rst                  (rst),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .slave_readdata       (slave_readdata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  always #5 clk = ~clk;

  // Memory slave: decides stall and data return each falling edge, so the DUT sees them next rise.
  initial begin : responder
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (prev_stall && (master_read !== 1'b1 || master_address !== prev_addr)) stall_viol++;
      master_readdatavalid = 1'b0;
      master_readdata      = 32'hDEADBEEF;
      if (pending) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          master_readdatavalid = 1'b1;
          master_readdata      = mem[pend_addr[11:2]];
          pending              = 1'b0;
        end
      end
      master_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      if (master_read === 1'b1 && !master_waitrequest) begin
        if (pending) overlap_viol++;
        pending   = 1'b1;
        pend_addr = master_address;
        pend_cnt  = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 8));
        accepts++;
        addr_log.push_back(master_address);
      end
      prev_stall = (master_read === 1'b1) && master_waitrequest;
      prev_addr  = master_address;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, output int waits);
    @(negedge clk);
    slave_address = a; slave_writedata = d; slave_write = 1'b1; waits = 0;
    #1;
    while (slave_waitrequest && waits < BUDGET) begin
      @(negedge clk); #1; waits++;
    end
    if (slave_waitrequest) begin
      vectors++; miscompares++;
      $display("[TB] FAIL bus_write timeout at offset %0d: got waitrequest=1 required 0", a);
    end
    @(posedge clk); #1;
    slave_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output int waits);
    @(negedge clk);
    slave_address = a; slave_read = 1'b1; waits = 0;
    #1;
    while (slave_waitrequest && waits < BUDGET) begin
      @(negedge clk); #1; waits++;
    end
    if (slave_waitrequest) begin
      vectors++; miscompares++;
      $display("[TB] FAIL bus_read timeout at offset %0d: got waitrequest=1 required 0", a);
    end
    d = slave_readdata;
    @(posedge clk); #1;
    slave_read = 1'b0;
  endtask

  function automatic logic [31:0] model_dot(input logic [31:0] wb, input logic [31:0] ib, input int n);
    logic [31:0] a, wa, xa, w, x;
    logic signed [63:0] ws, xs, p;
    a = 32'd0;
    for (int k = 0; k < n; k++) begin
      wa = wb + 32'(4 * k);
      xa = ib + 32'(4 * k);
      w  = mem[wa[11:2]];
      x  = mem[xa[11:2]];
      ws = {{32{w[31]}}, w};
      xs = {{32{x[31]}}, x};
      p  = ws * xs;
      a  = a + p[47:16];
    end
    return a;
  endfunction

  task automatic test_reset();
    logic [3:0]  offs [5];
    logic [31:0] rd;
    int          w;
    offs = '{4'd0, 4'd2, 4'd3, 4'd5, 4'd7};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    vectors++;
    if (slave_waitrequest !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_waitreq: got %b required 0", slave_waitrequest);
    end
    vectors++;
    if (master_read !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_master_read: got %b required 0", master_read);
    end
    vectors++;
    if (master_write !== 1'b0 || master_writedata !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_master_write: got %b/%h required 0/0", master_write, master_writedata);
    end
    for (int i = 0; i < 5; i++) begin
      bus_read(offs[i], rd, w);
      vectors++;
      if (rd !== 32'd0) begin
        miscompares++; $display("[TB] FAIL reset_reg%0d: got %h required 0", offs[i], rd);
      end
    end
  endtask

  task automatic test_config_regs();
    logic [3:0]  offs [3];
    logic [31:0] vals [3];
    logic [31:0] rd;
    int          w;
    offs = '{4'd2, 4'd3, 4'd5};
    vals = '{32'h12345678, 32'h9ABCDEF0, 32'h00000007};
    for (int i = 0; i < 3; i++) begin
      bus_write(offs[i], vals[i], w);
      vectors++;
      if (w !== 0) begin
        miscompares++; $display("[TB] FAIL cfg_write_stall%0d: got %0d waits required 0", offs[i], w);
      end
      bus_read(offs[i], rd, w);
      vectors++;
      if (rd !== vals[i]) begin
        miscompares++; $display("[TB] FAIL cfg_readback%0d: got %h required %h", offs[i], rd, vals[i]);
      end
    end
    bus_write(4'd1, 32'hFFFFFFFF, w);
    bus_read(4'd1, rd, w);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++; $display("[TB] FAIL unmapped_read1: got %h required 0", rd);
    end
    bus_read(4'd15, rd, w);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++; $display("[TB] FAIL unmapped_read15: got %h required 0", rd);
    end
  endtask

  task automatic test_directed();
    logic [31:0] rd;
    int          w, a0;
    mem[10'h040] = 32'h00010000; mem[10'h041] = 32'h00020000; mem[10'h042] = 32'hFFFF8000;
    mem[10'h060] = 32'h00020000; mem[10'h061] = 32'h00004000; mem[10'h062] = 32'h00040000;
    bus_write(4'd2, 32'h100, w);
    bus_write(4'd3, 32'h180, w);
    bus_write(4'd5, 32'd3, w);
    addr_log.delete();
    a0 = accepts;
    bus_write(4'd0, 32'd0, w);
    bus_read(4'd0, rd, w);
    vectors++;
    if (rd !== 32'h00008000) begin
      miscompares++; $display("[TB] FAIL directed_result: got %h required 00008000", rd);
    end
    vectors++;
    if (!(w > 0)) begin
      miscompares++; $display("[TB] FAIL directed_read_stall: got %0d waits required >0", w);
    end
    vectors++;
    if (accepts - a0 !== 6) begin
      miscompares++; $display("[TB] FAIL directed_reads: got %0d required 6", accepts - a0);
    end
    vectors++;
    if (addr_log.size() != 6 || addr_log[0] !== 32'h100 || addr_log[5] !== 32'h188) begin
      miscompares++;
      $display("[TB] FAIL directed_addrs: got %0d entries required 6 with first 100 last 188", addr_log.size());
    end
  endtask

  task automatic test_zero_length();
    logic [31:0] rd;
    int          w, a0;
    bus_write(4'd5, 32'd0, w);
    a0 = accepts;
    bus_write(4'd0, 32'd0, w);
    bus_read(4'd0, rd, w);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++; $display("[TB] FAIL zero_len_result: got %h required 0", rd);
    end
    vectors++;
    if (w > 3) begin
      miscompares++; $display("[TB] FAIL zero_len_latency: got %0d waits required <=3", w);
    end
    vectors++;
    if (accepts !== a0) begin
      miscompares++; $display("[TB] FAIL zero_len_reads: got %0d required 0", accepts - a0);
    end
  endtask

  task automatic test_busy_isolation();
    logic [31:0] rd;
    int          w;
    bus_write(4'd5, 32'd3, w);
    bus_write(4'd0, 32'd0, w);
    bus_write(4'd5, 32'd1, w);
    vectors++;
    if (w !== 0) begin
      miscompares++; $display("[TB] FAIL busy_cfg_stall: got %0d waits required 0", w);
    end
    bus_write(4'd2, 32'h104, w);
    bus_read(4'd0, rd, w);
    vectors++;
    if (rd !== 32'h00008000) begin
      miscompares++; $display("[TB] FAIL busy_isolation_result: got %h required 00008000", rd);
    end
    bus_read(4'd5, rd, w);
    vectors++;
    if (rd !== 32'd1) begin
      miscompares++; $display("[TB] FAIL busy_len_readback: got %h required 1", rd);
    end
    bus_read(4'd2, rd, w);
    vectors++;
    if (rd !== 32'h104) begin
      miscompares++; $display("[TB] FAIL busy_wbase_readback: got %h required 104", rd);
    end
    bus_write(4'd2, 32'h100, w);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int          w, a0;
    a0 = accepts;
    bus_write(4'd0, 32'd0, w);
    bus_write(4'd0, 32'd0, w);
    vectors++;
    if (!(w > 0)) begin
      miscompares++; $display("[TB] FAIL b2b_start_stall: got %0d waits required >0", w);
    end
    bus_read(4'd0, rd, w);
    vectors++;
    if (rd !== 32'h00020000) begin
      miscompares++; $display("[TB] FAIL b2b_result: got %h required 00020000", rd);
    end
    vectors++;
    if (accepts - a0 !== 4) begin
      miscompares++; $display("[TB] FAIL b2b_reads: got %0d required 4", accepts - a0);
    end
  endtask

  task automatic test_address_wrap();
    logic [31:0] rd;
    int          w;
    mem[10'h3FE] = 32'h00030000; mem[10'h3FF] = 32'hFFFE0000; mem[10'h000] = 32'h00008000;
    mem[10'h280] = 32'h00010000; mem[10'h281] = 32'h00018000; mem[10'h282] = 32'h00040000;
    bus_write(4'd2, 32'hFFFFFFF8, w);
    bus_write(4'd3, 32'h00000A00, w);
    bus_write(4'd5, 32'd3, w);
    addr_log.delete();
    bus_write(4'd0, 32'd0, w);
    bus_read(4'd0, rd, w);
    vectors++;
    if (rd !== 32'h00020000) begin
      miscompares++; $display("[TB] FAIL wrap_result: got %h required 00020000", rd);
    end
    vectors++;
    if (addr_log.size() != 6 || addr_log[4] !== 32'h0) begin
      miscompares++; $display("[TB] FAIL wrap_address: got %0d entries required 6 with w2 at 00000000", addr_log.size());
    end
  endtask

  task automatic test_random_stall();
    logic [31:0] rd, expd;
    int          w, a0;
    for (int k = 0; k < 16; k++) begin
      mem[10'h200 + 10'(k)] = $urandom();
      mem[10'h240 + 10'(k)] = $urandom();
    end
    expd = model_dot(32'h800, 32'h900, 16);
    bus_write(4'd2, 32'h800, w);
    bus_write(4'd3, 32'h900, w);
    bus_write(4'd5, 32'd16, w);
    overlap_viol = 0; stall_viol = 0;
    rand_wait = 1'b1; fixed_delay = 0;
    a0 = accepts;
    bus_write(4'd0, 32'd0, w);
    bus_read(4'd0, rd, w);
    rand_wait = 1'b0; fixed_delay = 1;
    vectors++;
    if (rd !== expd) begin
      miscompares++; $display("[TB] FAIL random_result: got %h required %h", rd, expd);
    end
    vectors++;
    if (accepts - a0 !== 32) begin
      miscompares++; $display("[TB] FAIL random_reads: got %0d required 32", accepts - a0);
    end
    vectors++;
    if (overlap_viol !== 0) begin
      miscompares++; $display("[TB] FAIL random_outstanding: got %0d overlaps required 0", overlap_viol);
    end
    vectors++;
    if (stall_viol !== 0) begin
      miscompares++; $display("[TB] FAIL random_addr_stable: got %0d changes required 0", stall_viol);
    end
  endtask

  task automatic test_relu();
    logic [31:0] rd;
    int          w;
    mem[10'h0C8] = 32'hFFFF0000; mem[10'h0C9] = 32'h00010000;
    bus_write(4'd2, 32'h320, w);
    bus_write(4'd3, 32'h324, w);
    bus_write(4'd5, 32'd1, w);
    bus_write(4'd7, 32'd1, w);
    bus_read(4'd7, rd, w);
    vectors++;
    if (rd !== RELU_READ) begin
      miscompares++; $display("[TB] FAIL relu_ctrl_read: got %h required %h", rd, RELU_READ);
    end
    bus_write(4'd0, 32'd0, w);
    bus_read(4'd0, rd, w);
    vectors++;
    if (rd !== RELU_NEG) begin
      miscompares++; $display("[TB] FAIL relu_on_result: got %h required %h", rd, RELU_NEG);
    end
    bus_write(4'd7, 32'd0, w);
    bus_write(4'd0, 32'd0, w);
    bus_read(4'd0, rd, w);
    vectors++;
    if (rd !== 32'hFFFF0000) begin
      miscompares++; $display("[TB] FAIL relu_off_result: got %h required FFFF0000", rd);
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] rd;
    int          w, n;
    mem[10'h043] = 32'h00010000; mem[10'h063] = 32'h00010000;
    mem[10'h0C0] = 32'h00010000; mem[10'h0C1] = 32'h00010000;
    bus_write(4'd2, 32'h100, w);
    bus_write(4'd3, 32'h180, w);
    bus_write(4'd5, 32'd4, w);
    fixed_delay = 6;
    addr_log.delete();
    bus_write(4'd0, 32'd0, w);
    n = 0;
    while (!(addr_log.size() > 0 && addr_log[addr_log.size() - 1] === 32'h180) && n < BUDGET) begin
      @(negedge clk); #1; n++;
    end
    vectors++;
    if (n >= BUDGET) begin
      miscompares++; $display("[TB] FAIL midrun_rd_i_seen: got timeout required input read");
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n = 0;
    while (pending && n < BUDGET) begin
      @(negedge clk); n++;
    end
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (master_read !== 1'b0) begin
      miscompares++; $display("[TB] FAIL midrun_master_read: got %b required 0", master_read);
    end
    bus_read(4'd0, rd, w);
    vectors++;
    if (rd !== 32'd0 || w !== 0) begin
      miscompares++; $display("[TB] FAIL midrun_result_cleared: got %h/%0d waits required 0/0", rd, w);
    end
    fixed_delay = 1;
    bus_write(4'd2, 32'h300, w);
    bus_write(4'd3, 32'h304, w);
    bus_write(4'd5, 32'd1, w);
    bus_write(4'd0, 32'd0, w);
    bus_read(4'd0, rd, w);
    vectors++;
    if (rd !== 32'h00010000) begin
      miscompares++; $display("[TB] FAIL midrun_new_run: got %h required 00010000", rd);
    end
  endtask

  initial begin
    $display("[TB] dnn_dot bench starting");
    test_reset();
    test_config_regs();
    test_directed();
    test_zero_length();
    test_busy_isolation();
    test_back_to_back();
    test_address_wrap();
    test_random_stall();
    test_relu();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
